// File: rtl/sha256_digest_serializer.sv
// sha256_digest_serializer
// Drains a captured SHA-256 digest as a byte stream over a valid/ready handshake.
// The output is raw bytes or lowercase ASCII hex, most significant byte first.
// A newline can optionally close each frame.
// A rising edge of digest_done starts a frame, and the whole digest is captured at that point.
// A rising edge that arrives while a frame is already in progress sets the sticky overrun flag.

module sha256_digest_serializer #(
  parameter int DIGEST_BYTES = 32,
  parameter int HEX_MODE     = 0,
  parameter int APPEND_NL    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [8*DIGEST_BYTES-1:0] digest_in,
  input  logic                      digest_done,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  localparam int DW   = 8 * DIGEST_BYTES;
  localparam int N    = DIGEST_BYTES * ((HEX_MODE != 0) ? 2 : 1) + ((APPEND_NL != 0) ? 1 : 0);
  localparam int CW   = $clog2(N + 1);
  localparam int STEP = (HEX_MODE != 0) ? 4 : 8;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_next;
  logic            done_prev;
  logic            rise;
  logic            xfer;
  logic [DW-1:0]   sreg, sreg_next;
  logic [CW-1:0]   count, count_next;
  logic [7:0]      out_data_next;
  logic            out_valid_next;
  logic            out_last_next;
  logic            overrun_next;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h57 + {4'h0, n};
  endfunction

  // The character for the unit at the top of the shift register: a byte, or the hex digit of a nibble
  function automatic logic [7:0] head_char(input logic [DW-1:0] v);
    if (HEX_MODE != 0) return hex_char(v[DW-1 -: 4]);
    else               return v[DW-1 -: 8];
  endfunction

  assign rise = digest_done & ~done_prev;
  assign xfer = out_valid & out_ready;
  assign busy = (state == SEND);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: a rise starts a frame, and the transfer of the final character ends it
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = SEND;
      SEND:    if (xfer && (count == LAST_IDX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and output next values: capture on a rise, advance one character per transfer
  always_comb begin
    sreg_next      = sreg;
    count_next     = count;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    out_last_next  = out_last;
    overrun_next   = overrun | (rise & (state == SEND));
    case (state)
      IDLE: begin
        if (rise) begin
          sreg_next      = digest_in << STEP;
          count_next     = '0;
          out_data_next  = head_char(digest_in);
          out_valid_next = 1'b1;
          out_last_next  = (LAST_IDX == '0);
        end
      end
      SEND: begin
        if (xfer) begin
          if (count == LAST_IDX) begin
            count_next     = '0;
            out_valid_next = 1'b0;
            out_last_next  = 1'b0;
          end else begin
            count_next    = count + CW'(1);
            sreg_next     = sreg << STEP;
            out_data_next = ((APPEND_NL != 0) && (count_next == LAST_IDX)) ? 8'h0A : head_char(sreg);
            out_last_next = (count_next == LAST_IDX);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered datapath, outputs, and the digest_done edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_prev <= 1'b0;
      sreg      <= '0;
      count     <= '0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      done_prev <= digest_done;
      sreg      <= sreg_next;
      count     <= count_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      out_last  <= out_last_next;
      overrun   <= overrun_next;
    end
  end

endmodule

// File: tb/tb_sha256_digest_serializer.sv
// tb_sha256_digest_serializer
// Directed bench with two instances: a raw-byte instance and a hex+newline instance.
// Expected characters are queued when a frame is triggered.
// They are popped and compared as each transfer happens.

module tb_sha256_digest_serializer;

  localparam logic [255:0] ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] OTHER = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] digest_in;

  logic         done_raw, ready_raw, valid_raw, last_raw, busy_raw, ovr_raw;
  logic [7:0]   data_raw;
  logic         done_hex, ready_hex, valid_hex, last_hex, busy_hex, ovr_hex;
  logic [7:0]   data_hex;

  logic [8:0]   exp_raw[$];
  logic [8:0]   exp_hex[$];
  logic [8:0]   exp_val;
  logic [8:0]   prev_raw, prev_hex;
  logic         stall_raw = 1'b0;
  logic         stall_hex = 1'b0;
  int           checks = 0;
  int           errors = 0;
  int           xfer_raw = 0;

  always #5 clk = ~clk;

  sha256_digest_serializer dut_raw (
    .clk(clk), .rst(rst), .digest_in(digest_in), .digest_done(done_raw),
    .out_data(data_raw), .out_valid(valid_raw), .out_ready(ready_raw),
    .out_last(last_raw), .busy(busy_raw), .overrun(ovr_raw)
  );

  sha256_digest_serializer #(.DIGEST_BYTES(32), .HEX_MODE(1), .APPEND_NL(1)) dut_hex (
    .clk(clk), .rst(rst), .digest_in(digest_in), .digest_done(done_hex),
    .out_data(data_hex), .out_valid(valid_hex), .out_ready(ready_hex),
    .out_last(last_hex), .busy(busy_hex), .overrun(ovr_hex)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic done, input logic ready);
    done_raw  = done;
    ready_raw = ready;
  endtask

  task automatic pushRaw(input logic [255:0] d);
    for (int k = 0; k < 32; k++) exp_raw.push_back({k == 31, d[255-8*k -: 8]});
  endtask

  task automatic pushHex(input logic [255:0] d);
    string      hexs;
    logic [3:0] nib;
    hexs = "0123456789abcdef";
    for (int k = 0; k < 64; k++) begin
      nib = d[255-4*k -: 4];
      exp_hex.push_back({1'b0, hexs[int'(nib)]});
    end
    exp_hex.push_back({1'b1, 8'h0A});
  endtask

  task automatic waitLeft(input bit use_hex, input int left, input string tag);
    int i;
    i = 0;
    while (((use_hex ? exp_hex.size() : exp_raw.size()) > left) && (i < 600)) begin
      tick(1);
      i++;
    end
    checkOutput(tag, 32'(use_hex ? exp_hex.size() : exp_raw.size()), 32'(left));
  endtask

  // Scoreboard monitor: compare every transfer, and check that stalled outputs hold
  always @(negedge clk) begin
    if (rst) begin
      stall_raw = 1'b0;
      stall_hex = 1'b0;
    end else begin
      if (stall_raw) begin
        checkOutput("raw_stall_valid", 32'(valid_raw), 32'd1);
        checkOutput("raw_stall_hold", 32'({last_raw, data_raw}), 32'(prev_raw));
      end
      if (valid_raw && ready_raw) begin
        exp_val = (exp_raw.size() > 0) ? exp_raw.pop_front() : 9'bx;
        checkOutput("raw_char", 32'({last_raw, data_raw}), 32'(exp_val));
        xfer_raw++;
      end
      stall_raw = valid_raw && !ready_raw;
      prev_raw  = {last_raw, data_raw};

      if (stall_hex) begin
        checkOutput("hex_stall_valid", 32'(valid_hex), 32'd1);
        checkOutput("hex_stall_hold", 32'({last_hex, data_hex}), 32'(prev_hex));
      end
      if (valid_hex && ready_hex) begin
        exp_val = (exp_hex.size() > 0) ? exp_hex.pop_front() : 9'bx;
        checkOutput("hex_char", 32'({last_hex, data_hex}), 32'(exp_val));
      end
      stall_hex = valid_hex && !ready_hex;
      prev_hex  = {last_hex, data_hex};
    end
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    rst = 1'b1;
    digest_in = ABC;
    applyStimulus(1'b0, 1'b0);
    done_hex = 1'b0;
    ready_hex = 1'b0;
    tick(3);
    checkOutput("reset_data", 32'(data_raw), 32'h0);
    checkOutput("reset_valid", 32'(valid_raw), 32'h0);
    checkOutput("reset_last", 32'(last_raw), 32'h0);
    checkOutput("reset_busy", 32'(busy_raw), 32'h0);
    checkOutput("reset_overrun", 32'(ovr_raw), 32'h0);
    checkOutput("reset_hex_valid", 32'(valid_hex), 32'h0);
    rst = 1'b0;
    tick(2);
    checkOutput("idle_valid", 32'(valid_raw), 32'h0);

    $display("[TB] T1 raw frame");
    xfer_raw = 0;
    pushRaw(ABC);
    applyStimulus(1'b1, 1'b1);
    checkOutput("t1_not_yet_valid", 32'(valid_raw), 32'h0);
    tick(1);
    checkOutput("t1_first_valid", 32'(valid_raw), 32'h1);
    checkOutput("t1_first_data", 32'(data_raw), 32'hBA);
    checkOutput("t1_busy", 32'(busy_raw), 32'h1);
    waitLeft(1'b0, 0, "t1_drain");
    checkOutput("t1_busy_end", 32'(busy_raw), 32'h0);
    checkOutput("t1_valid_end", 32'(valid_raw), 32'h0);
    checkOutput("t1_count", 32'(xfer_raw), 32'd32);

    $display("[TB] T2 hex frame with newline");
    ready_hex = 1'b1;
    pushHex(ABC);
    done_hex = 1'b1;
    tick(1);
    checkOutput("t2_first_valid", 32'(valid_hex), 32'h1);
    checkOutput("t2_first_data", 32'(data_hex), 32'h62);
    waitLeft(1'b1, 0, "t2_drain");
    checkOutput("t2_busy_end", 32'(busy_hex), 32'h0);
    done_hex = 1'b0;

    $display("[TB] T4 held digest_done, digest_in changed mid-frame");
    applyStimulus(1'b0, 1'b1);
    tick(2);
    xfer_raw = 0;
    pushRaw(ABC);
    applyStimulus(1'b1, 1'b1);
    tick(10);
    digest_in = OTHER;
    tick(190);
    checkOutput("t4_queue_empty", 32'(exp_raw.size()), 32'd0);
    checkOutput("t4_count", 32'(xfer_raw), 32'd32);
    checkOutput("t4_busy", 32'(busy_raw), 32'h0);
    checkOutput("t4_overrun", 32'(ovr_raw), 32'h0);
    digest_in = ABC;
    applyStimulus(1'b0, 1'b1);
    tick(2);

    $display("[TB] T3 backpressure");
    xfer_raw = 0;
    pushRaw(ABC);
    applyStimulus(1'b1, 1'b1);
    waitLeft(1'b0, 27, "t3_reach_char5");
    ready_raw = 1'b0;
    tick(3);
    checkOutput("t3_stall_valid", 32'(valid_raw), 32'h1);
    checkOutput("t3_stall_data", 32'(data_raw), 32'h01);
    for (int i = 0; (i < 400) && (exp_raw.size() > 0); i++) begin
      ready_raw = 1'($urandom_range(0, 1));
      tick(1);
    end
    ready_raw = 1'b1;
    waitLeft(1'b0, 0, "t3_drain");
    checkOutput("t3_count", 32'(xfer_raw), 32'd32);
    checkOutput("t3_busy_end", 32'(busy_raw), 32'h0);
    applyStimulus(1'b0, 1'b1);
    tick(2);

    $display("[TB] T5 second rise during a frame");
    xfer_raw = 0;
    pushRaw(ABC);
    applyStimulus(1'b1, 1'b1);
    waitLeft(1'b0, 22, "t5_reach_char10");
    checkOutput("t5_overrun_before", 32'(ovr_raw), 32'h0);
    done_raw = 1'b0;
    tick(1);
    done_raw = 1'b1;
    tick(2);
    checkOutput("t5_overrun_set", 32'(ovr_raw), 32'h1);
    checkOutput("t5_still_busy", 32'(busy_raw), 32'h1);
    waitLeft(1'b0, 0, "t5_drain");
    tick(20);
    checkOutput("t5_count", 32'(xfer_raw), 32'd32);
    checkOutput("t5_busy_end", 32'(busy_raw), 32'h0);
    checkOutput("t5_overrun_sticky", 32'(ovr_raw), 32'h1);
    applyStimulus(1'b0, 1'b1);
    tick(2);

    $display("[TB] T6 reset mid-frame");
    pushRaw(ABC);
    applyStimulus(1'b1, 1'b1);
    waitLeft(1'b0, 15, "t6_reach_char17");
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_data", 32'(data_raw), 32'h0);
    checkOutput("t6_rst_valid", 32'(valid_raw), 32'h0);
    checkOutput("t6_rst_last", 32'(last_raw), 32'h0);
    checkOutput("t6_rst_busy", 32'(busy_raw), 32'h0);
    checkOutput("t6_rst_overrun", 32'(ovr_raw), 32'h0);
    exp_raw.delete();
    tick(2);
    rst = 1'b0;
    xfer_raw = 0;
    pushRaw(ABC);
    checkOutput("t6_not_yet_valid", 32'(valid_raw), 32'h0);
    tick(1);
    checkOutput("t6_first_valid", 32'(valid_raw), 32'h1);
    checkOutput("t6_first_data", 32'(data_raw), 32'hBA);
    waitLeft(1'b0, 0, "t6_drain");
    checkOutput("t6_count", 32'(xfer_raw), 32'd32);
    checkOutput("t6_busy_end", 32'(busy_raw), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
